// File: rtl/doorlock_ctrl.sv
// Keypad door-lock FSM: 4-digit code entry, password change while open, open/lockout timers.
// All outputs registered (pulses one cycle after the key strobe); keys are accepted every cycle, no backpressure.
module doorlock_ctrl #(
  parameter logic [15:0] PW_INIT  = 16'h1234,
  parameter logic [25:0] OPEN_T   = 26'h2FA_F080,
  parameter logic [27:0] LOCK_T   = 28'hBEB_C200,
  parameter logic [1:0]  MAX_FAIL = 2'd3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       door_open,
  output logic       locked_out,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic [2:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  typedef enum logic [2:0] {IDLE, ENTRY, OPEN, SET, LOCK} state_t;

  localparam logic [3:0] KEY_CLR = 4'hA;
  localparam logic [3:0] KEY_ENT = 4'hB;

  state_t      state, state_nxt;
  logic [15:0] code_buf, buf_nxt;
  logic [15:0] pw, pw_nxt;
  logic [25:0] open_tmr, open_nxt;
  logic [27:0] lock_tmr, lock_nxt;
  logic [2:0]  cnt_nxt;
  logic [1:0]  fail_nxt, fail_inc;
  logic        ok_nxt, err_nxt;
  logic        is_digit, is_clr, is_ent, take_fail;

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign is_clr   = key_valid && (key_code == KEY_CLR);
  assign is_ent   = key_valid && (key_code == KEY_ENT);
  assign fail_inc = fail_cnt + 2'd1;

  always_comb begin
    state_nxt = state;
    buf_nxt   = code_buf;
    cnt_nxt   = digit_cnt;
    fail_nxt  = fail_cnt;
    pw_nxt    = pw;
    open_nxt  = open_tmr;
    lock_nxt  = lock_tmr;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    take_fail = 1'b0;

    // Shared digit shift for the states that collect digits; a full buffer ignores extras.
    if ((state == IDLE || state == ENTRY || state == SET) && is_digit && digit_cnt != 3'd4
        && !(state == SET && open_tmr == 26'd1)) begin
      buf_nxt = {code_buf[11:0], key_code};
      cnt_nxt = digit_cnt + 3'd1;
    end

    case (state)
      IDLE: begin
        if (is_digit) state_nxt = ENTRY;
        else if (is_ent) take_fail = 1'b1;
      end
      ENTRY: begin
        if (is_clr) begin
          buf_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (is_ent) begin
          buf_nxt = '0;
          cnt_nxt = '0;
          if (digit_cnt == 3'd4 && code_buf == pw) begin
            state_nxt = OPEN;
            ok_nxt    = 1'b1;
            fail_nxt  = '0;
            open_nxt  = OPEN_T;
          end else begin
            take_fail = 1'b1;
          end
        end
      end
      OPEN: begin
        if (open_tmr == 26'd1) begin
          state_nxt = IDLE;
          open_nxt  = '0;
        end else if (is_clr) begin
          state_nxt = SET;
          buf_nxt   = '0;
          cnt_nxt   = '0;
          open_nxt  = OPEN_T;
        end else begin
          open_nxt = open_tmr - 26'd1;
        end
      end
      SET: begin
        // Expiry takes priority over any key arriving in the same cycle.
        if (open_tmr == 26'd1 || is_clr || is_ent) begin
          state_nxt = IDLE;
          buf_nxt   = '0;
          cnt_nxt   = '0;
          open_nxt  = '0;
          if (open_tmr != 26'd1 && is_ent) begin
            if (digit_cnt == 3'd4) begin
              pw_nxt = code_buf;
              ok_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end else begin
          open_nxt = open_tmr - 26'd1;
        end
      end
      LOCK: begin
        if (lock_tmr == 28'd1) begin
          state_nxt = IDLE;
          lock_nxt  = '0;
          fail_nxt  = '0;
        end else begin
          lock_nxt = lock_tmr - 28'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (take_fail) begin
      err_nxt  = 1'b1;
      fail_nxt = fail_inc;
      if (fail_inc == MAX_FAIL) begin
        state_nxt = LOCK;
        lock_nxt  = LOCK_T;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      code_buf   <= '0;
      digit_cnt  <= '0;
      fail_cnt   <= '0;
      pw         <= PW_INIT;
      open_tmr   <= '0;
      lock_tmr   <= '0;
      ok_pulse   <= 1'b0;
      err_pulse  <= 1'b0;
      door_open  <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_nxt;
      code_buf   <= buf_nxt;
      digit_cnt  <= cnt_nxt;
      fail_cnt   <= fail_nxt;
      pw         <= pw_nxt;
      open_tmr   <= open_nxt;
      lock_tmr   <= lock_nxt;
      ok_pulse   <= ok_nxt;
      err_pulse  <= err_nxt;
      door_open  <= (state_nxt == OPEN) || (state_nxt == SET);
      locked_out <= (state_nxt == LOCK);
    end
  end

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Directed vector bench for doorlock_ctrl with short timers (open 10, lock 20 cycles).
module tb_doorlock_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       key_valid;
  logic [3:0] key_code;
  logic       door_open, locked_out, ok_pulse, err_pulse;
  logic [2:0] digit_cnt;
  logic [1:0] fail_cnt;

  doorlock_ctrl #(
    .PW_INIT (16'h1234),
    .OPEN_T  (26'd10),
    .LOCK_T  (28'd20),
    .MAX_FAIL(2'd3)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .door_open (door_open),
    .locked_out(locked_out),
    .ok_pulse  (ok_pulse),
    .err_pulse (err_pulse),
    .digit_cnt (digit_cnt),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       kv;
    logic [3:0] key;
    logic       ok;
    logic       err;
    logic       door;
    logic       lock;
    logic [2:0] dc;
    logic [1:0] fc;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void v(input logic kv, input logic [3:0] key, input logic ok, input logic err,
                            input logic door, input logic lock, input logic [2:0] dc, input logic [1:0] fc);
    vec_t t;
    t = '{kv: kv, key: key, ok: ok, err: err, door: door, lock: lock, dc: dc, fc: fc};
    vecs.push_back(t);
  endfunction

  function automatic void digits4(input logic [15:0] code, input logic door, input logic [1:0] fc);
    for (int i = 0; i < 4; i++) v(1'b1, code[15-4*i -: 4], 1'b0, 1'b0, door, 1'b0, 3'(i+1), fc);
  endfunction

  function automatic void idle(input int n, input logic door, input logic lock, input logic [2:0] dc,
                               input logic [1:0] fc);
    for (int i = 0; i < n; i++) v(1'b0, 4'h0, 1'b0, 1'b0, door, lock, dc, fc);
  endfunction

  // Door stays open for the ENT sample plus 9 more, then closes.
  function automatic void open_run();
    idle(9, 1'b1, 1'b0, 3'd0, 2'd0);
    idle(1, 1'b0, 1'b0, 3'd0, 2'd0);
  endfunction

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] got;
    got = {ok_pulse, err_pulse, door_open, locked_out, digit_cnt, fail_cnt};
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got ok/err/door/lock/dc/fc=%b required %b", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t t, input string name);
    @(negedge clk);
    key_valid = t.kv;
    key_code  = t.key;
    @(posedge clk);
    #1;
    check(name, {t.ok, t.err, t.door, t.lock, t.dc, t.fc});
  endtask

  initial begin
    vec_t t;
    n_rst     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;

    // Correct code opens the door for 10 cycles.
    digits4(16'h1234, 1'b0, 2'd0);
    v(1, 4'hB, 1, 0, 1, 0, 0, 0);
    open_run();

    // Three wrong codes lead to a 20-cycle lockout; keys in lockout are ignored.
    for (int i = 1; i <= 2; i++) begin
      digits4(16'h1235, 1'b0, 2'(i-1));
      v(1, 4'hB, 0, 1, 0, 0, 0, 2'(i));
    end
    digits4(16'h1235, 1'b0, 2'd2);
    v(1, 4'hB, 0, 1, 0, 1, 0, 3);
    v(1, 4'h1, 0, 0, 0, 1, 0, 3);
    v(1, 4'h2, 0, 0, 0, 1, 0, 3);
    v(1, 4'h3, 0, 0, 0, 1, 0, 3);
    v(1, 4'h4, 0, 0, 0, 1, 0, 3);
    v(1, 4'hB, 0, 0, 0, 1, 0, 3);
    idle(14, 1'b0, 1'b1, 3'd0, 2'd3);
    v(0, 4'h0, 0, 0, 0, 0, 0, 0);

    // Short code, fifth digit ignored, CLR mid-entry, ignored codes, ENT from IDLE.
    v(1, 4'h1, 0, 0, 0, 0, 1, 0);
    v(1, 4'h2, 0, 0, 0, 0, 2, 0);
    v(1, 4'h3, 0, 0, 0, 0, 3, 0);
    v(1, 4'hB, 0, 1, 0, 0, 0, 1);
    digits4(16'h1234, 1'b0, 2'd1);
    v(1, 4'h5, 0, 0, 0, 0, 4, 1);
    v(1, 4'hB, 1, 0, 1, 0, 0, 0);
    open_run();
    v(1, 4'h1, 0, 0, 0, 0, 1, 0);
    v(1, 4'hC, 0, 0, 0, 0, 1, 0);
    v(1, 4'h2, 0, 0, 0, 0, 2, 0);
    v(1, 4'hA, 0, 0, 0, 0, 0, 0);
    v(1, 4'hF, 0, 0, 0, 0, 0, 0);
    v(1, 4'hA, 0, 0, 0, 0, 0, 0);
    v(1, 4'hB, 0, 1, 0, 0, 0, 1);

    // Password change to 9876, then old code rejected and new code accepted.
    digits4(16'h1234, 1'b0, 2'd1);
    v(1, 4'hB, 1, 0, 1, 0, 0, 0);
    v(1, 4'hA, 0, 0, 1, 0, 0, 0);
    digits4(16'h9876, 1'b1, 2'd0);
    v(1, 4'hB, 1, 0, 0, 0, 0, 0);
    digits4(16'h1234, 1'b0, 2'd0);
    v(1, 4'hB, 0, 1, 0, 0, 0, 1);
    digits4(16'h9876, 1'b0, 2'd1);
    v(1, 4'hB, 1, 0, 1, 0, 0, 0);

    // ENT on the expiry cycle in SET is dropped; password stays 9876.
    v(1, 4'hA, 0, 0, 1, 0, 0, 0);
    digits4(16'h1234, 1'b1, 2'd0);
    idle(5, 1'b1, 1'b0, 3'd4, 2'd0);
    v(1, 4'hB, 0, 0, 0, 0, 0, 0);
    digits4(16'h1234, 1'b0, 2'd0);
    v(1, 4'hB, 0, 1, 0, 0, 0, 1);
    digits4(16'h9876, 1'b0, 2'd1);
    v(1, 4'hB, 1, 0, 1, 0, 0, 0);

    // Short ENT in SET aborts with err, fail_cnt untouched; CLR in SET aborts silently.
    v(1, 4'hA, 0, 0, 1, 0, 0, 0);
    v(1, 4'h1, 0, 0, 1, 0, 1, 0);
    v(1, 4'h2, 0, 0, 1, 0, 2, 0);
    v(1, 4'hB, 0, 1, 0, 0, 0, 0);
    digits4(16'h9876, 1'b0, 2'd0);
    v(1, 4'hB, 1, 0, 1, 0, 0, 0);
    v(1, 4'hA, 0, 0, 1, 0, 0, 0);
    v(1, 4'hA, 0, 0, 0, 0, 0, 0);
    digits4(16'h9876, 1'b0, 2'd0);
    v(1, 4'hB, 1, 0, 1, 0, 0, 0);
    idle(2, 1'b1, 1'b0, 3'd0, 2'd0);

    #1;
    check("reset_state", 9'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_idle", 9'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while the door is open.
    n_rst = 1'b0;
    #1;
    check("rst_mid_open", 9'b0);
    @(negedge clk);
    key_valid = 1'b0;
    n_rst     = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst_release", 9'b0);
    for (int i = 0; i < 4; i++) begin
      t = '{kv: 1'b1, key: 4'(i+1), ok: 1'b0, err: 1'b0, door: 1'b0, lock: 1'b0, dc: 3'(i+1), fc: 2'd0};
      apply(t, $sformatf("pw_restored_d%0d", i));
    end
    t = '{kv: 1'b1, key: 4'hB, ok: 1'b1, err: 1'b0, door: 1'b1, lock: 1'b0, dc: 3'd0, fc: 2'd0};
    apply(t, "pw_restored_ent");
    t = '{kv: 1'b0, key: 4'h0, ok: 1'b0, err: 1'b0, door: 1'b1, lock: 1'b0, dc: 3'd0, fc: 2'd0};
    apply(t, "pw_restored_open");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/doorlock_ctrl.md
Name: doorlock_ctrl

Overview:
- Keypad-driven door-lock controller. Collects a 4-digit code, compares it with a stored password, and manages door-open and lockout timing.
- Supports changing the password while the door is open.
- `ok_pulse` and `err_pulse` are single-cycle events that drive the downstream `delay_led` stages, which stretch each one into a 1 s LED indication.
- Sits between the keypad decoder (upstream, provides `key_valid`/`key_code`) and the LED stretchers and door actuator.

Parameters:
- `PW_INIT`, 16'h1234: password loaded at reset; 4 BCD digits, MSD in [15:12].
- `OPEN_T`, 26'h2FA_F080: door-open duration in clk cycles (1 s at 50 MHz).
- `LOCK_T`, 28'hBEB_C200: lockout duration in clk cycles (4 s at 50 MHz).
- `MAX_FAIL`, 2'd3: consecutive failed attempts that trigger lockout; legal range 1..3.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `n_rst`, input, 1: asynchronous active-low reset.
- `key_valid`, input, 1: one-cycle strobe, `key_code` valid.
- `key_code`, input, 4: 0..9 = digit, 4'hA = CLR (*), 4'hB = ENT (#), 4'hC..F = ignored.
- `door_open`, output, 1: high while in OPEN or SET.
- `locked_out`, output, 1: high while in LOCK.
- `ok_pulse`, output, 1: one-cycle pulse; code accepted or password changed.
- `err_pulse`, output, 1: one-cycle pulse; code rejected or password change aborted by a short ENT.
- `digit_cnt`, output, 3: digits currently buffered, 0..4.
- `fail_cnt`, output, 2: consecutive failed attempts.

Behaviour:
- Reset (async, `n_rst`=0):
  - State goes to IDLE; `pw` reloads `PW_INIT`, so a changed password is not retained.
  - Digit buffer, `digit_cnt`, `fail_cnt` and timers clear.
  - All outputs are 0.
  - Reset in any state, including mid-OPEN or mid-LOCK, aborts immediately.
- All outputs are registered. `ok_pulse` and `err_pulse` assert in the cycle after the `key_valid` cycle that caused them and last exactly 1 cycle. `ok_pulse` and `err_pulse` are never high together.
- Digit handling (IDLE, ENTRY, SET):
  - Each digit does `buf <= {buf[11:0], digit}`; `digit_cnt` increments.
  - At `digit_cnt`=4, further digits are ignored: buffer and count unchanged.
- State IDLE:
  - digit -> ENTRY, with `digit_cnt`=1.
  - ENT -> treated as a failed attempt (see ENTRY).
  - CLR -> no action.
- State ENTRY:
  - CLR -> clear buffer and count, go to IDLE, no pulse, `fail_cnt` unchanged.
  - ENT with `digit_cnt`=4 and `buf`==`pw` -> OPEN: `ok_pulse`, `fail_cnt`<=0, open timer loaded with `OPEN_T`.
  - ENT otherwise -> `err_pulse`, `fail_cnt`+1.
    - If the new `fail_cnt`==`MAX_FAIL` -> LOCK, lock timer loaded with `LOCK_T`.
    - Else -> IDLE.
  - Buffer and count clear on every ENT.
- State OPEN:
  - Open timer decrements each cycle; at 1 -> IDLE (door closes).
  - CLR -> SET: buffer cleared, open timer reloaded with `OPEN_T`.
  - Digits and ENT are ignored.
- State SET:
  - Open timer keeps running; expiry -> IDLE with `pw` unchanged, no pulse.
  - ENT with `digit_cnt`=4 -> `pw`<=`buf`, `ok_pulse`, go to IDLE.
  - ENT with `digit_cnt`<4 -> `err_pulse`, go to IDLE, `pw` unchanged, `fail_cnt` unchanged.
  - CLR -> IDLE, `pw` unchanged, no pulse.
- State LOCK:
  - All keys ignored.
  - Lock timer decrements; at 1 -> IDLE, `fail_cnt`<=0.
- Simultaneous events: if timer expiry and `key_valid` occur in the same cycle, expiry wins and the key is dropped.
- Ignored codes (4'hC..F) have no effect in any state.
- Timer widths: open timer 26 b, lock timer 28 b; neither timer wraps.

Test Plan (bench uses `OPEN_T`=10, `LOCK_T`=20, `MAX_FAIL`=3, `PW_INIT`=16'h1234):
- Correct code: keys 1,2,3,4,ENT -> `ok_pulse` 1 cycle after ENT; `door_open`=1 for exactly 10 cycles; `fail_cnt`=0; ends in IDLE.
- Wrong code and lockout: 3x (1,2,3,5,ENT) -> `err_pulse` each time; `fail_cnt` goes 1,2,3; `locked_out`=1 for 20 cycles. Keys 1,2,3,4,ENT during LOCK -> no pulse. After lockout, `fail_cnt`=0.
- Edge entries:
  - 1,2,3,ENT -> `err_pulse` (short code).
  - 1,2,3,4,5,ENT -> `ok_pulse` (5th digit ignored).
  - 1,2,CLR -> `digit_cnt`=0, no pulse.
- Password change: open with 1234, then CLR, 9,8,7,6,ENT -> `ok_pulse`. Then 1234,ENT -> `err_pulse`; 9876,ENT -> `ok_pulse`.
- Expiry collision: in SET, present a key on the same cycle the open timer expires -> key dropped, IDLE, `pw` unchanged.
- Reset mid-OPEN: assert `n_rst`=0 while in OPEN -> `door_open`=0 immediately. After release, `pw`=16'h1234 and all outputs 0.
